// File: rtl/button_press_decoder_if.sv
// Button decoder bus: debounced level in, one-cycle event pulses and busy out.
// master = upstream/consumer side, slave = the decoder itself.
interface button_press_decoder_if;
    logic button_level;
    logic short_press;
    logic long_press;
    logic double_press;
    logic busy;

    modport master (
        output button_level,
        input  short_press,
        input  long_press,
        input  double_press,
        input  busy
    );

    modport slave (
        input  button_level,
        output short_press,
        output long_press,
        output double_press,
        output busy
    );
endinterface

// File: rtl/button_press_decoder.sv
// Classifies presses on a debounced button level into short / long / double
// press events, each a registered one-cycle pulse.
// Optional feature macro: BUTTON_DOUBLE_EN (double-press detection; when it is
// enabled the short press is held back until the double-press gap expires).
module button_press_decoder #(
    parameter int unsigned clk_freq      = 95000, // kHz, one ms_tick per clk_freq cycles
    parameter int unsigned long_press_ms = 1000,
    parameter int unsigned double_gap_ms = 300
) (
    input  logic                          clk,
    input  logic                          rst,   // async, active low
    button_press_decoder_if.slave         bus
);

    // Elaboration-time range checks on the configuration.
    if (clk_freq < 1 || clk_freq > 32'h7FFF_FFFF) begin : g_bad_clk_freq
        $error("clk_freq out of range");
    end
    if (long_press_ms < 1 || long_press_ms > 65535) begin : g_bad_long_ms
        $error("long_press_ms out of range");
    end
    if (double_gap_ms < 1 || double_gap_ms > 65535) begin : g_bad_gap_ms
        $error("double_gap_ms out of range");
    end

    localparam logic [31:0] TICK_LAST = 32'(clk_freq - 1);
    localparam logic [15:0] LONG_MS   = 16'(long_press_ms);
`ifdef BUTTON_DOUBLE_EN
    localparam logic [15:0] GAP_MS    = 16'(double_gap_ms);
`endif

    typedef enum logic [2:0] {
        IDLE,
        PRESSED,
        HELD
`ifdef BUTTON_DOUBLE_EN
        ,
        GAP,
        SECOND
`endif
    } state_t;

    state_t      state;
    logic        level_q;
    logic        rise, fall;
    logic [31:0] tick_cnt;
    logic        ms_tick;
    logic [15:0] ms_cnt;
    logic        short_q, long_q;

    assign rise    =  bus.button_level & ~level_q;
    assign fall    = ~bus.button_level &  level_q;
    assign ms_tick = (tick_cnt == TICK_LAST);

    // Previous level for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) level_q <= 1'b0;
        else      level_q <= bus.button_level;
    end

    // Free-running 1 ms prescaler; never re-phased by the FSM, so the first
    // ms after a state change is anywhere between 1 cycle and a full ms.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         tick_cnt <= '0;
        else if (ms_tick) tick_cnt <= '0;
        else              tick_cnt <= tick_cnt + 32'd1;
    end

`ifdef BUTTON_DOUBLE_EN
    logic double_q;
`endif

    // Press classifier FSM with ms counter and registered event pulses.
    // ms_cnt restarts on every state change; edges take priority over timeouts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ms_cnt   <= '0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
`ifdef BUTTON_DOUBLE_EN
            double_q <= 1'b0;
`endif
        end else begin
            short_q  <= 1'b0;
            long_q   <= 1'b0;
`ifdef BUTTON_DOUBLE_EN
            double_q <= 1'b0;
`endif
            if (ms_tick && ms_cnt != 16'hFFFF) ms_cnt <= ms_cnt + 16'd1;

            case (state)
                IDLE: begin
                    if (rise) begin
                        state  <= PRESSED;
                        ms_cnt <= '0;
                    end
                end
                PRESSED: begin
                    if (fall) begin
                        ms_cnt  <= '0;
`ifdef BUTTON_DOUBLE_EN
                        state   <= GAP;
`else
                        state   <= IDLE;
                        short_q <= 1'b1;
`endif
                    end else if (ms_cnt >= LONG_MS) begin
                        state  <= HELD;
                        long_q <= 1'b1;
                        ms_cnt <= '0;
                    end
                end
                HELD: begin
                    if (fall) begin
                        state  <= IDLE;
                        ms_cnt <= '0;
                    end
                end
`ifdef BUTTON_DOUBLE_EN
                GAP: begin
                    if (rise) begin
                        state    <= SECOND;
                        double_q <= 1'b1;
                        ms_cnt   <= '0;
                    end else if (ms_cnt >= GAP_MS) begin
                        state   <= IDLE;
                        short_q <= 1'b1;
                        ms_cnt  <= '0;
                    end
                end
                SECOND: begin
                    // Second press never turns into a long press.
                    if (fall) begin
                        state  <= IDLE;
                        ms_cnt <= '0;
                    end
                end
`endif
                default: begin
                    state  <= IDLE;
                    ms_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.short_press  = short_q;
    assign bus.long_press   = long_q;
`ifdef BUTTON_DOUBLE_EN
    assign bus.double_press = double_q;
`else
    assign bus.double_press = 1'b0;
`endif
    assign bus.busy         = (state != IDLE);

endmodule
